sha256_block_sequencer: RTL and testbench
=========================================

SHA256_BLOCK_SEQUENCER -- requirements
Module: sha256_block_sequencer

Interface
REQ-001 Parameter ROUND_LAT, default 2: cycles from the last round counter value until the round engine's outputs hold the final state.
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 s_valid  in  1  message word valid.
REQ-006 s_ready  out  1  word accepted when s_valid&s_ready at a clk edge.
REQ-007 s_data  in  32  message word, big-endian (first word of a block first).
REQ-008 s_last  in  1  qualifies the 16th word of a block: that block is the message's final block.
REQ-009 gen_counter  out  6  round index driven to the round engine.
REQ-010 gen_word  out  32  schedule word driven to the round engine.
REQ-011 gen_hin  out  256  current chaining state H0..H7 (H0 in [255:224]) to the engine's A..H inputs.
REQ-012 gen_aa, gen_ab  in  32 each  engine A output as a carry-save pair; A = gen_aa+gen_ab mod 2^32.
REQ-013 gen_bh  in  224  engine B..H outputs (B in [223:192]).
REQ-014 digest  out  256  final hash (H0 in [255:224]).
REQ-015 digest_valid / digest_ready  out / in  1 each  digest handshake.
REQ-016 busy  out  1  high in every state except FILL with word count 0.

Function
REQ-017 States SHALL be FILL, RUN, DRAIN, UPDATE and OUT.
REQ-018 FILL: s_ready=1; each handshake writes s_data to buf[wcnt] and wcnt++ (0..15); s_last is ignored on words 0..14.
REQ-019 16th handshake: latch last_flag=s_last, wcnt->0, s_ready deasserts next cycle, go RUN.
REQ-020 RUN lasts exactly 64 cycles with gen_counter=0,1,...,63, one per cycle, no stalls.
REQ-021 During RUN: gen_word=buf[gen_counter] for gen_counter<16, else 32'h0.
REQ-022 DRAIN lasts ROUND_LAT cycles: gen_counter held at 63, gen_word=0.
REQ-023 UPDATE, one cycle: H0+=(gen_aa+gen_ab); H1..H7 += corresponding gen_bh fields; all additions mod 2^32, carries discarded.
REQ-024 After UPDATE, last_flag=0 -> FILL (next block chains the updated H).
REQ-025 After UPDATE, last_flag=1 -> OUT: digest=H, digest_valid=1, held stable until digest_ready.
REQ-026 OUT handshake: digest_valid->0, H reloads the IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19), go FILL.
REQ-027 Latency: 16th-word handshake edge to digest_valid high = 65+ROUND_LAT cycles (67 at default).
REQ-028 gen_hin SHALL equal H continuously and is unchanged throughout RUN and DRAIN.
REQ-029 s_valid gaps in FILL only pause filling; the partial buffer and wcnt are retained indefinitely.
REQ-030 digest_ready asserted outside OUT has no effect; s_valid outside FILL is not accepted.
REQ-031 gen_counter=0 and gen_word=0 in FILL, UPDATE and OUT.

Reset
REQ-032 On rst, at any state including mid-RUN: state=FILL, wcnt=0, last_flag=0, H=IV, digest=0, digest_valid=0, gen_counter=0, gen_word=0, buf contents don't-care.
REQ-033 Outputs after rst deassertion: s_ready=1, busy=0.

Verification
REQ-034 "abc" padded single block (61626380, 0 x14, 00000018), s_last on word 15 -> digest_valid 67 cycles later, digest=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
REQ-035 448-bit "abcdbcdecdefdefg..." message as two blocks, s_last only on block 2 -> one digest=248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1; no digest_valid after block 1.
REQ-036 "abc" with random s_valid gaps and digest_ready low for 10 cycles -> same digest, held stable while stalled; s_ready=0 throughout RUN, DRAIN, UPDATE and OUT.
REQ-037 rst pulse at RUN cycle 30, then "abc" -> digest=ba7816bf...f20015ad (the IV was restored).
REQ-038 Back-to-back "abc" messages, digest_ready tied high -> identical digests; gen_counter sequence 0..63 then 63 x2 observed per block.

Source files
------------

// File: rtl/sha256_block_sequencer.sv
`default_nettype none
// sha256_block_sequencer -- SHA-256 block buffer and round sequencer, rev 1.0
// Feeds an external round engine one block at a time, chains H and presents the digest.
module sha256_block_sequencer #(
   parameter int ROUND_LAT = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         s_valid,
   output logic         s_ready,
   input  logic [31:0]  s_data,
   input  logic         s_last,
   output logic [5:0]   gen_counter,
   output logic [31:0]  gen_word,
   output logic [255:0] gen_hin,
   input  logic [31:0]  gen_aa,
   input  logic [31:0]  gen_ab,
   input  logic [223:0] gen_bh,
   output logic [255:0] digest,
   output logic         digest_valid,
   input  logic         digest_ready,
   output logic         busy
);

   localparam logic [2:0] ST_FILL   = 3'd0;
   localparam logic [2:0] ST_RUN    = 3'd1;
   localparam logic [2:0] ST_DRAIN  = 3'd2;
   localparam logic [2:0] ST_UPDATE = 3'd3;
   localparam logic [2:0] ST_OUT    = 3'd4;

   localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                  32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

   localparam int                LAT_W      = (ROUND_LAT <= 2) ? 1 : $clog2(ROUND_LAT);
   localparam logic [LAT_W-1:0]  DRAIN_LAST = LAT_W'((ROUND_LAT > 0) ? ROUND_LAT - 1 : 0);

   logic [2:0]       state_q, state_d;
   logic [3:0]       wcnt_q, wcnt_d;
   logic             last_q, last_d;
   logic [255:0]     h_q, h_d;
   logic [255:0]     digest_q, digest_d;
   logic             dvalid_q, dvalid_d;
   logic [5:0]       ctr_q, ctr_d;
   logic [LAT_W-1:0] drain_q, drain_d;
   logic [31:0]      buf_q [16];
   logic [255:0]     h_sum;

   // Engine returns A as a carry-save pair; both halves fold into H0.
   always_comb begin
      h_sum[255:224] = h_q[255:224] + gen_aa + gen_ab;
      for (int i = 1; i < 8; i++) begin
         h_sum[255-32*i -: 32] = h_q[255-32*i -: 32] + gen_bh[223-32*(i-1) -: 32];
      end
   end

   always_comb begin
      state_d  = state_q;
      wcnt_d   = wcnt_q;
      last_d   = last_q;
      h_d      = h_q;
      digest_d = digest_q;
      dvalid_d = dvalid_q;
      ctr_d    = ctr_q;
      drain_d  = drain_q;
      case (state_q)
         ST_FILL: begin
            if (s_valid) begin
               wcnt_d = wcnt_q + 4'd1;
               if (wcnt_q == 4'd15) begin
                  last_d  = s_last;
                  ctr_d   = 6'd0;
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            if (ctr_q == 6'd63) begin
               drain_d = '0;
               state_d = (ROUND_LAT == 0) ? ST_UPDATE : ST_DRAIN;
            end else begin
               ctr_d = ctr_q + 6'd1;
            end
         end
         ST_DRAIN: begin
            if (drain_q == DRAIN_LAST) begin
               state_d = ST_UPDATE;
            end else begin
               drain_d = drain_q + 1'b1;
            end
         end
         ST_UPDATE: begin
            h_d   = h_sum;
            ctr_d = 6'd0;
            if (last_q) begin
               digest_d = h_sum;
               dvalid_d = 1'b1;
               state_d  = ST_OUT;
            end else begin
               state_d = ST_FILL;
            end
         end
         ST_OUT: begin
            if (digest_ready) begin
               dvalid_d = 1'b0;
               h_d      = IV;
               state_d  = ST_FILL;
            end
         end
         default: state_d = ST_FILL;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_FILL;
         wcnt_q   <= '0;
         last_q   <= 1'b0;
         h_q      <= IV;
         digest_q <= '0;
         dvalid_q <= 1'b0;
         ctr_q    <= '0;
         drain_q  <= '0;
      end else begin
         state_q  <= state_d;
         wcnt_q   <= wcnt_d;
         last_q   <= last_d;
         h_q      <= h_d;
         digest_q <= digest_d;
         dvalid_q <= dvalid_d;
         ctr_q    <= ctr_d;
         drain_q  <= drain_d;
      end
   end

   // Buffer needs no reset: every word is rewritten before it is read.
   always_ff @(posedge clk) begin
      if (state_q == ST_FILL && s_valid) begin
         buf_q[wcnt_q] <= s_data;
      end
   end

   assign s_ready      = (state_q == ST_FILL);
   assign busy         = !(state_q == ST_FILL && wcnt_q == 4'd0);
   assign gen_counter  = (state_q == ST_RUN || state_q == ST_DRAIN) ? ctr_q : 6'd0;
   assign gen_word     = (state_q == ST_RUN && ctr_q[5:4] == 2'b00) ? buf_q[ctr_q[3:0]] : 32'h0;
   assign gen_hin      = h_q;
   assign digest       = digest_q;
   assign digest_valid = dvalid_q;

endmodule
`default_nettype wire

// File: tb/tb_sha256_block_sequencer.sv
`default_nettype none
// tb_sha256_block_sequencer -- bench with a behavioural SHA-256 round engine and reference model.
module tb_sha256_block_sequencer;

   localparam int ROUND_LAT = 2;
   localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                  32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   localparam logic [511:0] BLK_ABC  = {32'h61626380, 448'h0, 32'h00000018};
   localparam logic [511:0] BLK_448A = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
   localparam logic [511:0] BLK_448B = {480'h0, 32'h000001c0};
   localparam logic [255:0] DIG_ABC  = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
   localparam logic [255:0] DIG_448  = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

   typedef struct {
      int                    nblk;
      logic [1:0][511:0]     blk;
      logic [255:0]          dig;
      int                    gap;
      int                    hold;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         s_valid = 1'b0;
   logic         s_ready;
   logic [31:0]  s_data = 32'h0;
   logic         s_last = 1'b0;
   logic [5:0]   gen_counter;
   logic [31:0]  gen_word;
   logic [255:0] gen_hin;
   logic [31:0]  gen_aa = 32'h0;
   logic [31:0]  gen_ab = 32'h0;
   logic [223:0] gen_bh = 224'h0;
   logic [255:0] digest;
   logic         digest_valid;
   logic         digest_ready = 1'b0;
   logic         busy;

   int           n_cmp = 0;
   int           n_err = 0;
   logic [255:0] exp_h = IV;
   logic         ready_tied = 1'b0;

   sha256_block_sequencer #(.ROUND_LAT(ROUND_LAT)) dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
      .gen_counter(gen_counter), .gen_word(gen_word), .gen_hin(gen_hin),
      .gen_aa(gen_aa), .gen_ab(gen_ab), .gen_bh(gen_bh),
      .digest(digest), .digest_valid(digest_valid), .digest_ready(digest_ready),
      .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // Full 64-round compression returning the working variables a..h (no feed-forward).
   function automatic logic [255:0] sha_rounds(input logic [255:0] hin, input logic [511:0] blk);
      logic [31:0] w [64];
      logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
      for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
      for (int t = 16; t < 64; t++) begin
         s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
         s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
         w[t] = w[t-16] + s0 + w[t-7] + s1;
      end
      {a, b, c, d, e, f, g, h} = hin;
      for (int t = 0; t < 64; t++) begin
         t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
         t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
         h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
      end
      return {a, b, c, d, e, f, g, h};
   endfunction

   function automatic logic [255:0] add256(input logic [255:0] x, input logic [255:0] y);
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
      return r;
   endfunction

   // Round engine: collects words 0..15 by index, answers ROUND_LAT cycles after round 63.
   logic [511:0] eng_blk = 512'h0;
   logic [255:0] eng_res = 256'h0;
   logic [31:0]  eng_split = 32'h0;
   logic [5:0]   eng_prev = 6'd0;
   int           eng_pend = 0;
   always @(negedge clk) begin
      if (rst) begin
         eng_pend <= 0;
         eng_prev <= 6'd0;
      end else begin
         if (gen_counter < 6'd16) eng_blk[511 - 32*int'(gen_counter) -: 32] <= gen_word;
         if (gen_counter == 6'd63 && eng_prev == 6'd62) begin
            eng_res   <= sha_rounds(gen_hin, eng_blk);
            eng_split <= $urandom;
            eng_pend  <= ROUND_LAT;
            gen_aa    <= $urandom;
            gen_ab    <= $urandom;
            gen_bh    <= {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         end else if (eng_pend == 1) begin
            gen_aa   <= eng_split;
            gen_ab   <= eng_res[255:224] - eng_split;
            gen_bh   <= eng_res[223:0];
            eng_pend <= 0;
         end else if (eng_pend > 1) begin
            eng_pend <= eng_pend - 1;
         end
         eng_prev <= gen_counter;
      end
   end

   task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic send_block(input logic [511:0] blk, input logic last, input int gap);
      int n;
      for (int i = 0; i < 16; i++) begin
         while ($urandom_range(99) < gap) begin
            s_valid = 1'b0;
            s_data  = $urandom;
            s_last  = 1'($urandom);
            @(posedge clk); #1;
         end
         s_valid = 1'b1;
         s_data  = blk[511-32*i -: 32];
         s_last  = (i == 15) ? last : 1'($urandom);
         n = 0;
         while (!s_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
         end
         if (n >= 100) begin
            n_cmp++;
            n_err++;
            $display("FAIL fill_ready: s_ready stayed %0b, expected 1", s_ready);
         end
         @(posedge clk); #1;
         if (i == 0) check("busy_partial", 256'(busy), 256'(1));
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   // Follows RUN, DRAIN and UPDATE cycle by cycle; also offers stray words that must be refused.
   task automatic monitor_block(input logic [511:0] blk, input logic last);
      int          bad = 0;
      logic [31:0] ew;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (i == 3) begin s_valid = 1'b1; s_data = $urandom; end
         if (i == 8) s_valid = 1'b0;
         if (i < 16) ew = blk[511-32*i -: 32];
         else        ew = 32'h0;
         if (gen_counter != 6'(i) || gen_word != ew || s_ready || !busy || gen_hin != exp_h) bad++;
      end
      for (int i = 0; i < ROUND_LAT; i++) begin
         @(negedge clk);
         if (gen_counter != 6'd63 || gen_word != 32'h0 || s_ready || gen_hin != exp_h) bad++;
      end
      @(negedge clk);
      if (gen_counter != 6'd0 || gen_word != 32'h0 || s_ready || digest_valid || gen_hin != exp_h) bad++;
      check("round_seq", 256'(bad), 256'(0));
      exp_h = add256(exp_h, sha_rounds(exp_h, blk));
      @(negedge clk);
      check("dv_latency", 256'(digest_valid), 256'(last));
      check("h_chain", gen_hin, exp_h);
      if (!last) check("refill", 256'({s_ready, busy}), 256'(2'b10));
   endtask

   task automatic wait_digest(input logic [255:0] exp, input int hold, input string nm);
      int n = 0;
      int bad = 0;
      while (!digest_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      check({nm, "_valid"}, 256'(digest_valid), 256'(1));
      check(nm, digest, exp);
      if (hold > 0) begin
         digest_ready = 1'b0;
         repeat (hold) begin
            @(negedge clk);
            if (!digest_valid || digest !== exp || s_ready || gen_counter != 6'd0) bad++;
         end
         check("out_hold", 256'(bad), 256'(0));
      end
      digest_ready = 1'b1;
      @(posedge clk); #1;
      if (!ready_tied) digest_ready = 1'b0;
      check("out_handshake", 256'({digest_valid, s_ready, busy}), 256'(3'b010));
      check("iv_reload", gen_hin, IV);
      exp_h = IV;
   endtask

   initial begin
      vec_t         tbl [3];
      logic [511:0] rb [3];
      logic [255:0] d;
      int           nb, gap, hold;

      tbl[0].nblk = 1; tbl[0].blk[0] = BLK_ABC;  tbl[0].blk[1] = 512'h0;
      tbl[0].dig = DIG_ABC; tbl[0].gap = 0;  tbl[0].hold = 0;
      tbl[1].nblk = 2; tbl[1].blk[0] = BLK_448A; tbl[1].blk[1] = BLK_448B;
      tbl[1].dig = DIG_448; tbl[1].gap = 0;  tbl[1].hold = 3;
      tbl[2].nblk = 1; tbl[2].blk[0] = BLK_ABC;  tbl[2].blk[1] = 512'h0;
      tbl[2].dig = DIG_ABC; tbl[2].gap = 35; tbl[2].hold = 10;

      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_gen", 256'({gen_counter, gen_word}), 256'(0));
      check("rst_hin", gen_hin, IV);
      check("rst_digest", digest, 256'h0);
      rst = 1'b0;
      @(negedge clk);
      check("rst_flags", 256'({digest_valid, s_ready, busy}), 256'(3'b010));

      for (int v = 0; v < 3; v++) begin
         for (int b = 0; b < tbl[v].nblk; b++) begin
            send_block(tbl[v].blk[b], 1'(b == tbl[v].nblk - 1), tbl[v].gap);
            monitor_block(tbl[v].blk[b], 1'(b == tbl[v].nblk - 1));
         end
         wait_digest(tbl[v].dig, tbl[v].hold, "tbl_digest");
      end

      for (int m = 0; m < 5; m++) begin
         nb = $urandom_range(1, 3);
         for (int b = 0; b < 3; b++)
            for (int w = 0; w < 16; w++) rb[b][511-32*w -: 32] = $urandom;
         d = IV;
         for (int b = 0; b < nb; b++) d = add256(d, sha_rounds(d, rb[b]));
         gap  = $urandom_range(0, 40);
         hold = $urandom_range(0, 4);
         for (int b = 0; b < nb; b++) begin
            send_block(rb[b], 1'(b == nb - 1), gap);
            monitor_block(rb[b], 1'(b == nb - 1));
         end
         wait_digest(d, hold, "rnd_digest");
      end

      ready_tied   = 1'b1;
      digest_ready = 1'b1;
      for (int r = 0; r < 2; r++) begin
         send_block(BLK_ABC, 1'b1, 0);
         monitor_block(BLK_ABC, 1'b1);
         wait_digest(DIG_ABC, 0, "b2b_digest");
      end
      ready_tied   = 1'b0;
      digest_ready = 1'b0;

      // Chain H away from the IV, then reset in the middle of the next block's rounds.
      send_block(BLK_448A, 1'b0, 0);
      monitor_block(BLK_448A, 1'b0);
      send_block(BLK_448B, 1'b1, 0);
      repeat (31) @(negedge clk);
      check("mid_run_ctr", 256'(gen_counter), 256'(30));
      rst = 1'b1;
      #2;
      check("mid_rst_gen", 256'({gen_counter, gen_word}), 256'(0));
      check("mid_rst_hin", gen_hin, IV);
      check("mid_rst_flags", 256'({digest_valid, s_ready, busy}), 256'(3'b010));
      @(negedge clk);
      rst = 1'b0;
      exp_h = IV;
      @(negedge clk);
      send_block(BLK_ABC, 1'b1, 0);
      monitor_block(BLK_ABC, 1'b1);
      wait_digest(DIG_ABC, 2, "post_rst_digest");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, expected summary first");
      $fatal(1);
   end

endmodule
`default_nettype wire
